// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data requests win; each access is a held MReq/MReady handshake with lane formatting and timeout abort.
module mem_port_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRdata,
  output logic        IValid,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  input  logic [1:0]  DSize,
  input  logic        DSign,
  output logic [31:0] DRdata,
  output logic        DValid,
  output logic        MReq,
  output logic        MWe,
  output logic [31:0] MAddr,
  output logic [31:0] MWdata,
  output logic [3:0]  MBe,
  input  logic        MReady,
  input  logic [31:0] MRdata,
  output logic        StallF,
  output logic        StallM,
  output logic        BusErr,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] INST = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          mreq_q, mreq_d;
  logic          mwe_q, mwe_d;
  logic [31:0]   maddr_q, maddr_d;
  logic [31:0]   mwdata_q, mwdata_d;
  logic [3:0]    mbe_q, mbe_d;
  logic [31:0]   irdata_q, irdata_d;
  logic          ivalid_q, ivalid_d;
  logic [31:0]   drdata_q, drdata_d;
  logic          dvalid_q, dvalid_d;
  logic          buserr_q, buserr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ofs_q, ofs_d;
  logic [1:0]    size_q, size_d;
  logic          sign_q, sign_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        misaligned;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic        d_live;
  logic        i_live;
  logic        timeout_hit;
  logic        unused_iaddr_lsb;

  assign unused_iaddr_lsb = ^IAddr[1:0];

  always_comb begin
    lane_be    = 4'hf;
    lane_wdata = DWdata;
    misaligned = 1'b0;
    unique case (DSize)
      2'b00: begin
        lane_be    = 4'b0001 << DAddr[1:0];
        lane_wdata = {4{DWdata[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << DAddr[1:0];
        lane_wdata = {2{DWdata[15:0]}};
        misaligned = DAddr[0];
      end
      default: begin
        misaligned = (DAddr[1:0] != 2'b00);
      end
    endcase
  end

  // Load lane is shifted down to bit 0 first, then extended by size.
  always_comb begin
    shifted   = MRdata >> {ofs_q, 3'b000};
    load_data = shifted;
    unique case (size_q)
      2'b00:   load_data = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Handshake: a request is live while Req=1 and its own Valid is not pulsing;
  // MReq stays high with stable address/data until MReady=1 or the timeout fires,
  // and the result appears as a one-cycle Valid pulse on the following cycle.
  assign d_live      = DReq & ~dvalid_q;
  assign i_live      = IReq & ~ivalid_q;
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mbe_d    = mbe_q;
    irdata_d = irdata_q;
    ivalid_d = 1'b0;
    drdata_d = drdata_q;
    dvalid_d = 1'b0;
    buserr_d = 1'b0;
    cnt_d    = cnt_q;
    ofs_d    = ofs_q;
    size_d   = size_q;
    sign_d   = sign_q;
    unique case (state_q)
      IDLE: begin
        if (d_live) begin
          if (misaligned) begin
            dvalid_d = 1'b1;
            buserr_d = 1'b1;
            drdata_d = '0;
          end else begin
            state_d  = DATA;
            mreq_d   = 1'b1;
            mwe_d    = DWe;
            maddr_d  = {DAddr[31:2], 2'b00};
            mwdata_d = lane_wdata;
            mbe_d    = lane_be;
            cnt_d    = '0;
            ofs_d    = DAddr[1:0];
            size_d   = DSize;
            sign_d   = DSign;
          end
        end else if (i_live) begin
          state_d  = INST;
          mreq_d   = 1'b1;
          mwe_d    = 1'b0;
          maddr_d  = {IAddr[31:2], 2'b00};
          mwdata_d = '0;
          mbe_d    = 4'hf;
          cnt_d    = '0;
        end
      end
      DATA, INST: begin
        if (MReady || timeout_hit) begin
          state_d  = IDLE;
          mreq_d   = 1'b0;
          mwe_d    = 1'b0;
          maddr_d  = '0;
          mwdata_d = '0;
          mbe_d    = '0;
          buserr_d = ~MReady;
          if (state_q == INST) begin
            ivalid_d = 1'b1;
            irdata_d = MReady ? MRdata : '0;
          end else begin
            dvalid_d = 1'b1;
            drdata_d = (MReady && !mwe_q) ? load_data : '0;
          end
        end
        if (!MReady) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        mreq_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mbe_q    <= '0;
      irdata_q <= '0;
      ivalid_q <= 1'b0;
      drdata_q <= '0;
      dvalid_q <= 1'b0;
      buserr_q <= 1'b0;
      cnt_q    <= '0;
      ofs_q    <= '0;
      size_q   <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mbe_q    <= mbe_d;
      irdata_q <= irdata_d;
      ivalid_q <= ivalid_d;
      drdata_q <= drdata_d;
      dvalid_q <= dvalid_d;
      buserr_q <= buserr_d;
      cnt_q    <= cnt_d;
      ofs_q    <= ofs_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
    end
  end

  assign IRdata    = irdata_q;
  assign IValid    = ivalid_q;
  assign DRdata    = drdata_q;
  assign DValid    = dvalid_q;
  assign MReq      = mreq_q;
  assign MWe       = mwe_q;
  assign MAddr     = maddr_q;
  assign MWdata    = mwdata_q;
  assign MBe       = mbe_q;
  assign BusErr    = buserr_q;
  assign StallF    = IReq & ~ivalid_q;
  assign StallM    = DReq & ~dvalid_q;
  assign dbg_state = state_q;

endmodule
